// File: rtl/cfu_pkg.sv
// Shared CFU types: response status codes, the share-tag carried alongside an
// in-flight request, and the round-robin pick helper used by the sharer.
package cfu_pkg;

    localparam int MAX_REQ = 16;
    localparam int OWNER_W = 4;

    typedef enum logic [2:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_OFF    = 3'd1,
        CFU_ERROR_FUNC   = 3'd2,
        CFU_ERROR_OP     = 3'd3,
        CFU_ERROR_STATE  = 3'd4,
        CFU_ERROR_CUSTOM = 3'd7
    } cfu_status_t;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               local_err;
    } cfu_share_tag_t;

    typedef struct packed {
        logic               found;
        logic [OWNER_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[0..n-1] searching upward from ptr, wrapping at n.
    // Scanning offsets high-to-low lets the smallest offset win.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [OWNER_W-1:0] ptr,
                                         input int n);
        rr_pick_t           r;
        logic [OWNER_W-1:0] idx;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = OWNER_W'((int'(ptr) + k) % n);
                if (valid[idx]) begin
                    r.found = 1'b1;
                    r.idx   = idx;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_reg.sv
// Enable-gated delay line of N stages, W bits wide; N=0 degenerates to wires.
module shift_reg #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (N == 0) begin : g_wire
        assign q = d;
    end else begin : g_regs
        logic [W-1:0] stages [N];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < N; i++) stages[i] <= '0;
            end else if (en) begin
                stages[0] <= d;
                for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
            end
        end

        assign q = stages[N-1];
    end

endmodule

// File: rtl/cfu_l1_rr_share.sv
// Round-robin sharer of one fixed-latency CFU among N_REQ requesters, with
// per-requester state windows; CFU_RR_SHARE_PERF_EN adds grant/stall counters.
module cfu_l1_rr_share
    import cfu_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int LAT            = 2,
    parameter int STATES_PER_REQ = 1,
    parameter int FUNC_ID_W      = 10,
    parameter int DATA_W         = 32,
    parameter int STATE_W        = 4,
    parameter int CSTATE_W       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*FUNC_ID_W-1:0] req_func,
    input  logic [N_REQ*STATE_W-1:0]   req_state,
    input  logic [N_REQ*DATA_W-1:0]    req_data0,
    input  logic [N_REQ*DATA_W-1:0]    req_data1,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [2:0]                 resp_status,
    output logic [DATA_W-1:0]          resp_data,
    output logic                       cfu_req_valid,
    output logic [FUNC_ID_W-1:0]       cfu_req_func,
    output logic [CSTATE_W-1:0]        cfu_req_state,
    output logic [DATA_W-1:0]          cfu_req_data0,
    output logic [DATA_W-1:0]          cfu_req_data1,
    input  logic                       cfu_resp_valid,
    input  logic [2:0]                 cfu_resp_status,
    input  logic [DATA_W-1:0]          cfu_resp_data
`ifdef CFU_RR_SHARE_PERF_EN
    ,
    output logic [N_REQ*32-1:0]        perf_grants,
    output logic [N_REQ*32-1:0]        perf_stalls
`endif
);

    localparam int TAG_W = $bits(cfu_share_tag_t);

    logic [OWNER_W-1:0]   ptr;
    rr_pick_t             pick;
    logic                 grant_found;
    logic [OWNER_W-1:0]   grant_idx;
    logic [FUNC_ID_W-1:0] sel_func;
    logic [STATE_W-1:0]   sel_state;
    logic [DATA_W-1:0]    sel_data0;
    logic [DATA_W-1:0]    sel_data1;
    logic                 local_err;
    cfu_share_tag_t       tag_in;
    cfu_share_tag_t       tag_out;
    logic [TAG_W-1:0]     tag_out_bits;

    // Arbiter and payload mux; the payload is picked by grant index only.
    always_comb begin
        pick        = rr_pick(MAX_REQ'(req_valid), ptr, N_REQ);
        grant_found = pick.found && clk_en && !rst;
        grant_idx   = pick.idx;
        req_ready   = '0;
        sel_func    = '0;
        sel_state   = '0;
        sel_data0   = '0;
        sel_data1   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == OWNER_W'(i)) begin
                req_ready[i] = grant_found;
                sel_func     = req_func[i*FUNC_ID_W +: FUNC_ID_W];
                sel_state    = req_state[i*STATE_W +: STATE_W];
                sel_data0    = req_data0[i*DATA_W +: DATA_W];
                sel_data1    = req_data1[i*DATA_W +: DATA_W];
            end
        end
        local_err        = int'(sel_state) >= STATES_PER_REQ;
        cfu_req_valid    = grant_found && !local_err;
        cfu_req_func     = sel_func;
        cfu_req_state    = CSTATE_W'(int'(grant_idx) * STATES_PER_REQ + int'(sel_state));
        cfu_req_data0    = sel_data0;
        cfu_req_data1    = sel_data1;
        tag_in.valid     = grant_found;
        tag_in.owner     = grant_idx;
        tag_in.local_err = local_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_found) begin
            ptr <= (grant_idx == OWNER_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    shift_reg #(
        .W(TAG_W),
        .N(LAT)
    ) u_tag_pipe (
        .clk(clk),
        .rst(rst),
        .en (clk_en),
        .d  (tag_in),
        .q  (tag_out_bits)
    );

    assign tag_out = cfu_share_tag_t'(tag_out_bits);

    // Local-error tags answer without the CFU; others forward its result.
    always_comb begin
        resp_valid  = '0;
        resp_status = CFU_OK;
        resp_data   = '0;
        if (tag_out.valid) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (tag_out.owner == OWNER_W'(i)) resp_valid[i] = 1'b1;
            end
            if (tag_out.local_err) begin
                resp_status = CFU_ERROR_STATE;
            end else begin
                resp_status = cfu_resp_status;
                resp_data   = cfu_resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && clk_en) begin
            a_cfu_resp_matches_tag: assert (cfu_resp_valid == (tag_out.valid && !tag_out.local_err));
        end
    end

`ifdef CFU_RR_SHARE_PERF_EN
    logic [31:0] grants_q [N_REQ];
    logic [31:0] stalls_q [N_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                grants_q[i] <= '0;
                stalls_q[i] <= '0;
            end
        end else if (clk_en) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && grants_q[i] != '1) grants_q[i] <= grants_q[i] + 32'd1;
                if (req_valid[i] && !req_ready[i] && stalls_q[i] != '1)
                    stalls_q[i] <= stalls_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        perf_grants = '0;
        perf_stalls = '0;
        for (int i = 0; i < N_REQ; i++) begin
            perf_grants[i*32 +: 32] = grants_q[i];
            perf_stalls[i*32 +: 32] = stalls_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cfu_l1_rr_share.sv
// Randomised scoreboard bench for cfu_l1_rr_share with a behavioural CFU and
// a round-robin reference model kept in bench-level integers and queues.
module tb_cfu_l1_rr_share;
    import cfu_pkg::*;

    localparam int N_REQ     = 4;
    localparam int LAT       = 2;
    localparam int SPR       = 1;
    localparam int FUNC_ID_W = 10;
    localparam int DATA_W    = 32;
    localparam int STATE_W   = 4;
    localparam int CSTATE_W  = 6;
    localparam int EXP_W     = 32 + 4 + 3 + DATA_W;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       clk_en;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*FUNC_ID_W-1:0] req_func;
    logic [N_REQ*STATE_W-1:0]   req_state;
    logic [N_REQ*DATA_W-1:0]    req_data0;
    logic [N_REQ*DATA_W-1:0]    req_data1;
    logic [N_REQ-1:0]           resp_valid;
    logic [2:0]                 resp_status;
    logic [DATA_W-1:0]          resp_data;
    logic                       cfu_req_valid;
    logic [FUNC_ID_W-1:0]       cfu_req_func;
    logic [CSTATE_W-1:0]        cfu_req_state;
    logic [DATA_W-1:0]          cfu_req_data0;
    logic [DATA_W-1:0]          cfu_req_data1;
    logic                       cfu_resp_valid;
    logic [2:0]                 cfu_resp_status;
    logic [DATA_W-1:0]          cfu_resp_data;
`ifdef CFU_RR_SHARE_PERF_EN
    logic [N_REQ*32-1:0]        perf_grants;
    logic [N_REQ*32-1:0]        perf_stalls;
`endif

    cfu_l1_rr_share #(
        .N_REQ(N_REQ), .LAT(LAT), .STATES_PER_REQ(SPR), .FUNC_ID_W(FUNC_ID_W),
        .DATA_W(DATA_W), .STATE_W(STATE_W), .CSTATE_W(CSTATE_W)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_state(req_state), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_data(resp_data),
        .cfu_req_valid(cfu_req_valid), .cfu_req_func(cfu_req_func),
        .cfu_req_state(cfu_req_state), .cfu_req_data0(cfu_req_data0),
        .cfu_req_data1(cfu_req_data1), .cfu_resp_valid(cfu_resp_valid),
        .cfu_resp_status(cfu_resp_status), .cfu_resp_data(cfu_resp_data)
`ifdef CFU_RR_SHARE_PERF_EN
        , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int en_cyc = 0;
    always @(posedge clk) if (clk_en && !rst) en_cyc <= en_cyc + 1;

    // ---------------- behavioural CFU ----------------
    function automatic logic [DATA_W-1:0] cfu_op(input logic [FUNC_ID_W-1:0] f,
                                                 input logic [CSTATE_W-1:0] cs,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a + (b ^ 32'(f))) ^ (32'(cs) << 26);
    endfunction

    function automatic logic [2:0] cfu_stat(input logic [FUNC_ID_W-1:0] f);
        return (f[3:0] == 4'hF) ? 3'd2 : 3'd0;
    endfunction

    logic              m_v [LAT];
    logic [2:0]        m_s [LAT];
    logic [DATA_W-1:0] m_d [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) m_v[i] <= 1'b0;
        end else if (clk_en) begin
            m_v[0] <= cfu_req_valid;
            m_s[0] <= cfu_stat(cfu_req_func);
            m_d[0] <= cfu_op(cfu_req_func, cfu_req_state, cfu_req_data0, cfu_req_data1);
            for (int i = 1; i < LAT; i++) begin
                m_v[i] <= m_v[i-1];
                m_s[i] <= m_s[i-1];
                m_d[i] <= m_d[i-1];
            end
        end
    end

    assign cfu_resp_valid  = m_v[LAT-1];
    assign cfu_resp_status = m_s[LAT-1];
    assign cfu_resp_data   = m_d[LAT-1];

    // ---------------- stimulus payload ----------------
    logic [FUNC_ID_W-1:0] f_a [N_REQ];
    logic [STATE_W-1:0]   s_a [N_REQ];
    logic [DATA_W-1:0]    a_a [N_REQ];
    logic [DATA_W-1:0]    b_a [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_func[i*FUNC_ID_W +: FUNC_ID_W] = f_a[i];
            req_state[i*STATE_W +: STATE_W]    = s_a[i];
            req_data0[i*DATA_W +: DATA_W]      = a_a[i];
            req_data1[i*DATA_W +: DATA_W]      = b_a[i];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EXP_W-1:0] exp_q[$];
    int mptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int model_grant(input logic [N_REQ-1:0] v, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    // Grant check and expectation push, done mid-cycle once inputs settle.
    task automatic check_grant();
        int g;
        logic err;
        logic [2:0] st;
        logic [DATA_W-1:0] d;
        logic [CSTATE_W-1:0] cs;
        g = (clk_en && !rst) ? model_grant(req_valid, mptr) : -1;
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
        if (g >= 0) begin
            err = int'(s_a[g]) >= SPR;
            chk("cfu_req_valid", 64'(cfu_req_valid), 64'(!err));
            if (!err) begin
                cs = CSTATE_W'(g * SPR + int'(s_a[g]));
                chk("cfu_req_state", 64'(cfu_req_state), 64'(cs));
                st = cfu_stat(f_a[g]);
                d  = cfu_op(f_a[g], cs, a_a[g], b_a[g]);
            end else begin
                st = 3'd4;
                d  = '0;
            end
            exp_q.push_back({32'(en_cyc + LAT), 4'(g), st, d});
            mptr = (g + 1) % N_REQ;
        end else begin
            chk("cfu_req_valid_idle", 64'(cfu_req_valid), 64'(0));
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [N_REQ-1:0] v, input logic en,
                         input logic [N_REQ-1:0] err_mask, input int err_pct);
        clk_en    = en;
        req_valid = v;
        for (int i = 0; i < N_REQ; i++) begin
            f_a[i] = FUNC_ID_W'($urandom);
            a_a[i] = $urandom;
            b_a[i] = $urandom;
            if (err_mask[i] || int'($urandom_range(99)) < err_pct)
                s_a[i] = STATE_W'($urandom_range(15, SPR));
            else
                s_a[i] = STATE_W'($urandom_range(SPR - 1, 0));
        end
        @(negedge clk);
        check_grant();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b1;
        mptr = 0;
        exp_q.delete();
        repeat (n) cycle('1, 1'b1, '0, 0);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic [EXP_W-1:0] mon_e;

    always @(negedge clk) begin
        if (!rst && clk_en) begin
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_owner", 64'(resp_valid), 64'(1) << mon_e[DATA_W+3 +: 4]);
                    chk("resp_status", 64'(resp_status), 64'(mon_e[DATA_W +: 3]));
                    chk("resp_data", 64'(resp_data), 64'(mon_e[DATA_W-1:0]));
                    chk("resp_latency", 64'(en_cyc), 64'(mon_e[EXP_W-1 -: 32]));
                end
            end else begin
                chk("idle_resp", {29'b0, resp_status, resp_data}, 64'(0));
                if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) <= en_cyc) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_missing", 64'(0), 64'(1));
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        rst       = 1'b1;
        clk_en    = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            f_a[i] = '0; s_a[i] = '0; a_a[i] = '0; b_a[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset(2);
        chk("reset_resp_valid", 64'(resp_valid), 64'(0));

        repeat (8) cycle('1, 1'b1, '0, 0);            // grants 0,1,2,3,0,1,2,3
        repeat (LAT + 1) cycle('0, 1'b1, '0, 0);
        repeat (6) cycle(4'b0100, 1'b1, '0, 0);       // requester 2 alone
        repeat (3) cycle(4'b0010, 1'b1, 4'b0010, 0);  // out-of-window state
        repeat (LAT + 1) cycle('0, 1'b1, '0, 0);

        repeat (2) cycle('1, 1'b1, '0, 0);            // two in flight, then freeze
        repeat (3) cycle('1, 1'b0, '0, 0);
        repeat (LAT + 1) cycle('0, 1'b1, '0, 0);

        repeat (2) cycle('1, 1'b1, '0, 0);            // reset with two in flight
        do_reset(2);
        cycle(4'b1100, 1'b1, '0, 0);
        repeat (LAT + 2) cycle('0, 1'b1, '0, 0);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) == 0) do_reset(1);
            cycle(N_REQ'($urandom), $urandom_range(99) < 85, '0, 15);
        end

`ifdef CFU_RR_SHARE_PERF_EN
        do_reset(1);
        repeat (10) cycle(4'b0011, 1'b1, '0, 0);
        chk("perf_grants0", 64'(perf_grants[31:0]), 64'(5));
        chk("perf_grants1", 64'(perf_grants[63:32]), 64'(5));
        chk("perf_stalls0", 64'(perf_stalls[31:0]), 64'(5));
        chk("perf_stalls1", 64'(perf_stalls[63:32]), 64'(5));
        chk("perf_grants2", 64'(perf_grants[95:64]), 64'(0));
`endif

        repeat (LAT + 2) cycle('0, 1'b1, '0, 0);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
